// File: rtl/maxpool2_col_stage.sv
// maxpool2_col_stage
//   Streaming 2x2 / stride-2 FP16 max-pool placed after the conv array.
//   Each input column (IN_ROWS values) arrives on a single-cycle in_valid
//   pulse. Even columns are reduced row-pairwise into a holding buffer.
//   Odd columns are reduced the same way and combined with that buffer to
//   produce one pooled column of IN_ROWS/2 values. There is no backpressure.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start        : frame-start pulse; arms the block, clears col count and col_err
//   in_valid     : input column strobe
//   in_data      : input column, index 0 = top row
//   in_col_num   : upstream 1-based column number (sequence check only)
//   out_valid    : one-cycle pooled-column strobe
//   out_data     : pooled column (held until the next out_valid)
//   out_col_num  : 0-based pooled column index
//   done         : one-cycle end-of-frame pulse
//   col_err      : sticky column-sequence mismatch flag
module maxpool2_col_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_ROWS    = 24,
  parameter int IN_COLS    = 24,
  parameter int RELU_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data [IN_ROWS],
  input  logic [$clog2(IN_COLS):0]     in_col_num,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data [IN_ROWS/2],
  output logic [$clog2(IN_COLS):0]     out_col_num,
  output logic                         done,
  output logic                         col_err
);

  localparam int OUT_ROWS = IN_ROWS / 2;
  localparam int CW       = $clog2(IN_COLS) + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS);

  typedef enum logic [1:0] {IDLE, WAIT_EVEN, WAIT_ODD} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         col_cnt_reg;
  logic [CW-1:0]         col_cnt_inc;
  logic                  col_err_reg;
  logic                  out_valid_reg;
  logic                  done_reg;
  logic [CW-1:0]         out_col_num_reg;
  logic [DATA_WIDTH-1:0] buf_reg      [OUT_ROWS];
  logic [DATA_WIDTH-1:0] out_data_reg [OUT_ROWS];
  logic [DATA_WIDTH-1:0] pair_max     [OUT_ROWS];
  logic [DATA_WIDTH-1:0] pooled       [OUT_ROWS];

  logic accept;
  logic last_col;
  logic emit;

  // Unsigned ordering key for FP16. Both zeros map to the +0 key so that
  // -0 and +0 tie; NaN/Inf simply fall where their key puts them.
  function automatic logic [DATA_WIDTH-1:0] ord_key(input logic [DATA_WIDTH-1:0] v);
    if (v[DATA_WIDTH-2:0] == '0)
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else if (v[DATA_WIDTH-1])
      return ~v;
    else
      return {1'b1, v[DATA_WIDTH-2:0]};
  endfunction

  // First operand wins unless the second is strictly greater.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (ord_key(b) > ord_key(a)) ? b : a;
  endfunction

  // start swallows any in_valid in the same cycle; IDLE ignores in_valid.
  assign accept      = in_valid && !start && (state_reg != IDLE);
  assign col_cnt_inc = col_cnt_reg + 1'b1;
  assign last_col    = accept && (col_cnt_inc == LAST_COL);
  assign emit        = accept && (state_reg == WAIT_ODD);

  genvar gi;
  generate
    for (gi = 0; gi < OUT_ROWS; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] res;
      assign pair_max[gi] = fmax(in_data[2*gi], in_data[2*gi+1]);
      // Buffered (earlier) column is the left operand so it wins ties.
      assign res          = fmax(buf_reg[gi], pair_max[gi]);
      assign pooled[gi]   = ((RELU_EN != 0) && res[DATA_WIDTH-1]) ? '0 : res;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = WAIT_EVEN;
    end else begin
      case (state_reg)
        IDLE:      state_next = IDLE;
        WAIT_EVEN: if (accept) state_next = last_col ? IDLE : WAIT_ODD;
        WAIT_ODD:  if (accept) state_next = last_col ? IDLE : WAIT_EVEN;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      col_cnt_reg     <= '0;
      col_err_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      done_reg        <= 1'b0;
      out_col_num_reg <= '0;
      for (int r = 0; r < OUT_ROWS; r++) begin
        buf_reg[r]      <= '0;
        out_data_reg[r] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= emit;
      done_reg      <= last_col;
      if (start) begin
        // Partial buffer needs no clearing: the next even column overwrites it.
        col_cnt_reg <= '0;
        col_err_reg <= 1'b0;
      end else if (accept) begin
        col_cnt_reg <= col_cnt_inc;
        if (in_col_num != col_cnt_inc)
          col_err_reg <= 1'b1;
        if (state_reg == WAIT_EVEN) begin
          for (int r = 0; r < OUT_ROWS; r++)
            buf_reg[r] <= pair_max[r];
        end
        if (emit) begin
          out_col_num_reg <= col_cnt_reg >> 1;
          for (int r = 0; r < OUT_ROWS; r++)
            out_data_reg[r] <= pooled[r];
        end
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_col_num = out_col_num_reg;
  assign done        = done_reg;
  assign col_err     = col_err_reg;

endmodule

// File: tb/tb_maxpool2_col_stage.sv
module tb_maxpool2_col_stage;

  localparam int ROWS = 4;
  localparam int COLS = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data [ROWS];
  logic [5:0]  in_col_num = '0;
  logic [2:0]  col_num_c;

  logic        a_valid, b_valid, c_valid;
  logic [15:0] a_data [ROWS/2];
  logic [15:0] b_data [ROWS/2];
  logic [15:0] c_data [ROWS/2];
  logic [5:0]  a_num, b_num;
  logic [2:0]  c_num;
  logic        a_done, b_done, c_done;
  logic        a_err, b_err, c_err;

  int checks = 0;
  int failures = 0;

  assign col_num_c = in_col_num[2:0];

  always #5 clk = ~clk;

  maxpool2_col_stage #(.DATA_WIDTH(16), .IN_ROWS(ROWS), .IN_COLS(COLS), .RELU_EN(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_col_num(in_col_num), .out_valid(a_valid), .out_data(a_data),
    .out_col_num(a_num), .done(a_done), .col_err(a_err));

  maxpool2_col_stage #(.DATA_WIDTH(16), .IN_ROWS(ROWS), .IN_COLS(COLS), .RELU_EN(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_col_num(in_col_num), .out_valid(b_valid), .out_data(b_data),
    .out_col_num(b_num), .done(b_done), .col_err(b_err));

  // Odd column count: trailing column produces done only.
  maxpool2_col_stage #(.DATA_WIDTH(16), .IN_ROWS(ROWS), .IN_COLS(3), .RELU_EN(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_col_num(col_num_c), .out_valid(c_valid), .out_data(c_data),
    .out_col_num(c_num), .done(c_done), .col_err(c_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic v, input logic [5:0] n,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    start      = s;
    in_valid   = v;
    in_col_num = n;
    in_data[0] = d0; in_data[1] = d1; in_data[2] = d2; in_data[3] = d3;
    tick();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] fp_key(input logic [15:0] v);
    if (v[14:0] == 15'd0) return 16'h8000;
    return v[15] ? ~v : (v | 16'h8000);
  endfunction

  // First element of the group holding the largest key.
  function automatic logic [15:0] group_max(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] d);
    logic [15:0] g [4];
    logic [15:0] best;
    g[0] = a; g[1] = b; g[2] = c; g[3] = d;
    best = g[0];
    for (int i = 1; i < 4; i++)
      if (fp_key(g[i]) > fp_key(best)) best = g[i];
    return best;
  endfunction

  bit          m_armed;
  int          m_ncols;
  bit          m_err;
  logic [15:0] m_pend [ROWS];
  bit          m_valid, m_done;
  int          m_num;
  logic [15:0] m_relu [ROWS/2];
  logic [15:0] m_raw  [ROWS/2];

  task automatic model_reset();
    m_armed = 0; m_ncols = 0; m_err = 0; m_valid = 0; m_done = 0; m_num = 0;
    for (int r = 0; r < ROWS/2; r++) begin m_relu[r] = 0; m_raw[r] = 0; end
    for (int r = 0; r < ROWS; r++) m_pend[r] = 0;
  endtask

  // Expected outputs after the coming clock edge, given the current inputs.
  task automatic model_step();
    m_valid = 0; m_done = 0;
    if (start) begin
      m_armed = 1; m_ncols = 0; m_err = 0;
    end else if (in_valid && m_armed) begin
      if (int'(in_col_num) != m_ncols + 1) m_err = 1;
      m_ncols++;
      if (m_ncols % 2 == 1) begin
        for (int r = 0; r < ROWS; r++) m_pend[r] = in_data[r];
      end else begin
        for (int r = 0; r < ROWS/2; r++) begin
          m_raw[r]  = group_max(m_pend[2*r], m_pend[2*r+1], in_data[2*r], in_data[2*r+1]);
          m_relu[r] = m_raw[r][15] ? 16'h0000 : m_raw[r];
        end
        m_valid = 1;
        m_num   = (m_ncols - 1) / 2;
      end
      if (m_ncols == COLS) begin m_armed = 0; m_done = 1; end
    end
  endtask

  function automatic logic [15:0] rnd_fp();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7C00;
      3: return 16'hFC00;
      4: return 16'(16'h3C00 ^ 16'($urandom_range(0, 3)));
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] ev [4];
    logic [15:0] od [4];
    logic [15:0] exp_relu [2];
    logic [15:0] exp_raw [2];
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0].ev = '{16'h3C00, 16'h4000, 16'hC200, 16'h3800};
    tbl[0].od = '{16'h3800, 16'h3C00, 16'hC400, 16'hC200};
    tbl[0].exp_relu = '{16'h4000, 16'h3800};
    tbl[0].exp_raw  = '{16'h4000, 16'h3800};
    tbl[1].ev = '{16'hC200, 16'hC400, 16'h8000, 16'h0000};
    tbl[1].od = '{16'hBC00, 16'hC000, 16'h8000, 16'h8000};
    tbl[1].exp_relu = '{16'h0000, 16'h0000};
    tbl[1].exp_raw  = '{16'hBC00, 16'h8000};
    tbl[2].ev = '{16'h0000, 16'h8000, 16'h7C00, 16'h7C00};
    tbl[2].od = '{16'h8000, 16'h0000, 16'h3C00, 16'h7BFF};
    tbl[2].exp_relu = '{16'h0000, 16'h7C00};
    tbl[2].exp_raw  = '{16'h0000, 16'h7C00};
    tbl[3].ev = '{16'h7E00, 16'h7C00, 16'h8001, 16'h0001};
    tbl[3].od = '{16'hFE00, 16'h0000, 16'h8001, 16'h8002};
    tbl[3].exp_relu = '{16'h7E00, 16'h0001};
    tbl[3].exp_raw  = '{16'h7E00, 16'h0001};

    for (int r = 0; r < ROWS; r++) in_data[r] = 16'h0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_num", 32'(a_num), 0);
    chk("rst_data0", 32'(a_data[0]), 0);
    chk("rst_c_done", 32'(c_done), 0);
    rst = 1'b0;

    // Table-driven pooling vectors
    for (int t = 0; t < 4; t++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, tbl[t].ev[0], tbl[t].ev[1], tbl[t].ev[2], tbl[t].ev[3]);
      chk($sformatf("tbl%0d_even_novalid", t), 32'(a_valid), 0);
      step(0, 1, 2, tbl[t].od[0], tbl[t].od[1], tbl[t].od[2], tbl[t].od[3]);
      chk($sformatf("tbl%0d_valid", t), 32'(a_valid), 1);
      chk($sformatf("tbl%0d_num", t), 32'(a_num), 0);
      chk($sformatf("tbl%0d_err", t), 32'(a_err), 0);
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("tbl%0d_relu%0d", t, r), 32'(a_data[r]), 32'(tbl[t].exp_relu[r]));
        chk($sformatf("tbl%0d_raw%0d", t, r), 32'(b_data[r]), 32'(tbl[t].exp_raw[r]));
      end
      idle();
      chk($sformatf("tbl%0d_pulse", t), 32'(a_valid), 0);
    end

    // Full frame, back-to-back columns
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= COLS; k++) begin
      step(0, 1, 6'(k), rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp());
      chk($sformatf("frame_valid_c%0d", k), 32'(a_valid), 32'(k % 2 == 0));
      chk($sformatf("frame_done_c%0d", k), 32'(a_done), 32'(k == COLS));
      if (k % 2 == 0) chk($sformatf("frame_num_c%0d", k), 32'(a_num), 32'(k / 2 - 1));
    end
    step(0, 1, 25, 16'h5000, 16'h5000, 16'h5000, 16'h5000);
    chk("frame_after_valid", 32'(a_valid), 0);
    chk("frame_after_done", 32'(a_done), 0);
    step(0, 1, 26, 16'h5000, 16'h5000, 16'h5000, 16'h5000);
    chk("frame_idle_valid", 32'(a_valid), 0);
    chk("frame_idle_err", 32'(a_err), 0);
    chk("frame_idle_num", 32'(a_num), 11);

    // Sequence error
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 16'h3C00, 16'h0, 16'h0, 16'h0);
    step(0, 1, 2, 16'h3C00, 16'h0, 16'h0, 16'h0);
    chk("seq_ok", 32'(a_err), 0);
    step(0, 1, 4, 16'h3C00, 16'h0, 16'h0, 16'h0);
    chk("seq_err_set", 32'(a_err), 1);
    step(0, 1, 4, 16'h3C00, 16'h0, 16'h0, 16'h0);
    chk("seq_err_sticky", 32'(a_err), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("seq_err_cleared", 32'(a_err), 0);

    // start mid-frame drops the coincident column and discards buffer
    step(0, 1, 1, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    step(0, 1, 2, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    step(0, 1, 3, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
    step(1, 1, 4, 16'h7800, 16'h7800, 16'h7800, 16'h7800);
    chk("midstart_drop", 32'(a_valid), 0);
    step(0, 1, 1, 16'h3800, 16'h3400, 16'h3000, 16'h2C00);
    chk("midstart_even", 32'(a_valid), 0);
    step(0, 1, 2, 16'h3400, 16'h3800, 16'h2C00, 16'h3000);
    chk("midstart_valid", 32'(a_valid), 1);
    chk("midstart_num", 32'(a_num), 0);
    chk("midstart_d0", 32'(a_data[0]), 32'h3800);
    chk("midstart_d1", 32'(a_data[1]), 32'h3000);
    chk("midstart_err", 32'(a_err), 0);

    // rst while waiting for the odd column
    step(0, 1, 3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(a_valid), 0);
    chk("rst_mid_data0", 32'(a_data[0]), 0);
    chk("rst_mid_data1", 32'(a_data[1]), 0);
    chk("rst_mid_done", 32'(a_done), 0);
    step(0, 1, 4, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    chk("rst_mid_ignored", 32'(a_valid), 0);
    chk("rst_mid_ignored_err", 32'(a_err), 0);
    step(0, 1, 1, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    chk("rst_mid_ignored2", 32'(a_valid), 0);

    // Odd IN_COLS instance: trailing column gives done without output
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 16'h3C00, 16'h0, 16'h0, 16'h0);
    step(0, 1, 2, 16'h4000, 16'h0, 16'h0, 16'h0);
    chk("odd_valid", 32'(c_valid), 1);
    chk("odd_num", 32'(c_num), 0);
    chk("odd_d0", 32'(c_data[0]), 32'h4000);
    chk("odd_nodone_yet", 32'(c_done), 0);
    step(0, 1, 3, 16'h7000, 16'h0, 16'h0, 16'h0);
    chk("odd_trail_valid", 32'(c_valid), 0);
    chk("odd_trail_done", 32'(c_done), 1);
    step(0, 1, 4, 16'h7000, 16'h0, 16'h0, 16'h0);
    chk("odd_done_pulse", 32'(c_done), 0);
    chk("odd_idle_valid", 32'(c_valid), 0);
    chk("odd_hold_d0", 32'(c_data[0]), 32'h4000);

    // Randomized run against the reference model
    rst = 1'b1;
    idle();
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic s, v;
      logic [5:0] n;
      s = ($urandom_range(0, 59) == 0) || (cyc == 2);
      v = ($urandom_range(0, 3) != 0);
      n = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 30)) : 6'(m_ncols + 1);
      step_nowait(s, v, n);
      model_step();
      tick();
      chk("rnd_valid_a", 32'(a_valid), 32'(m_valid));
      chk("rnd_valid_b", 32'(b_valid), 32'(m_valid));
      chk("rnd_done", 32'(a_done), 32'(m_done));
      chk("rnd_err", 32'(a_err), 32'(m_err));
      chk("rnd_num", 32'(a_num), 32'(m_num));
      for (int r = 0; r < ROWS/2; r++) begin
        chk("rnd_relu", 32'(a_data[r]), 32'(m_relu[r]));
        chk("rnd_raw", 32'(b_data[r]), 32'(m_raw[r]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic step_nowait(input logic s, input logic v, input logic [5:0] n);
    start      = s;
    in_valid   = v;
    in_col_num = n;
    for (int r = 0; r < ROWS; r++) in_data[r] = rnd_fp();
  endtask

endmodule
